// File: rtl/deser_pkg.sv
// ============================================================================
// Module      : deser_pkg
// Description : Shared types and helpers for the flexible deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deser_pkg;

  typedef enum logic {
    LSB_FIRST_E = 1'b0,
    MSB_FIRST_E = 1'b1
  } bit_order_e;

  // Width able to hold any length from 0 up to and including data_w.
  function automatic int calc_len_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/deser_out_hold.sv
// ============================================================================
// Module      : deser_out_hold
// Description : One-word valid/ready holding register with drop/overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deser_out_hold #(
  parameter int PAYLOAD_W = 21
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 emit_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic                 val_o,
  output logic                 overflow_o
);

  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_val;
  logic                 r_ovf;
  logic                 w_load;

  // A held word being accepted this cycle frees the slot for a new one.
  assign w_load = emit_i && (!r_val || ready_i);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_payload <= '0;
      r_val     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= emit_i && !w_load;
      if (w_load) begin
        r_payload <= payload_i;
        r_val     <= 1'b1;
      end else if (r_val && ready_i) begin
        r_val <= 1'b0;
      end
    end
  end

  assign payload_o  = r_payload;
  assign val_o      = r_val;
  assign overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: rtl/deserializer_flex.sv
// ============================================================================
// Module      : deserializer_flex
// Description : Serial-to-parallel collector with flush, bit order select and
//               valid/ready output holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer_flex
  import deser_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int LEN_W     = calc_len_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_len_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i,
  output logic              overflow_o
);

  localparam bit_order_e c_order = MSB_FIRST ? MSB_FIRST_E : LSB_FIRST_E;

  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sr;
  logic [DATA_W-1:0] w_sr_in;
  logic              w_full;
  logic              w_flush;
  logic              w_emit;
  logic [LEN_W-1:0]  w_len;

  // w_sr_in is the shift register with the current bit already folded in,
  // so a completing or flushed word always includes this cycle's bit.
  generate
    if (c_order == MSB_FIRST_E) begin : g_msb_first
      always_comb begin
        w_sr_in = r_sr;
        if (data_val_i) begin
          w_sr_in = {r_sr[DATA_W-2:0], data_i};
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_sr_in = r_sr;
        if (data_val_i) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) == r_cnt) begin
              w_sr_in[i] = data_i;
            end
          end
        end
      end
    end
  endgenerate

  assign w_full  = data_val_i && (r_cnt == LEN_W'(DATA_W - 1));
  assign w_flush = flush_i && ((r_cnt != '0) || data_val_i);
  assign w_emit  = w_full || w_flush;
  assign w_len   = w_full ? LEN_W'(DATA_W) : (r_cnt + LEN_W'(data_val_i));

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (w_emit) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (data_val_i) begin
      r_cnt <= r_cnt + LEN_W'(1);
      r_sr  <= w_sr_in;
    end
  end

  deser_out_hold #(
    .PAYLOAD_W (DATA_W + LEN_W)
  ) u_out_hold (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .emit_i     (w_emit),
    .payload_i  ({w_sr_in, w_len}),
    .ready_i    (deser_data_ready_i),
    .payload_o  ({deser_data_o, deser_len_o}),
    .val_o      (deser_data_val_o),
    .overflow_o (overflow_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_deserializer_flex.sv
// ============================================================================
// Module      : tb_deserializer_flex
// Description : Bench for a 16-bit MSB-first and an 8-bit LSB-first instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializer_flex;

  logic        clk = 1'b0;
  logic        srst;
  logic        d    [2];
  logic        v    [2];
  logic        f    [2];
  logic        rdy  [2];
  logic        val_o[2];
  logic        ovf_o[2];
  logic [15:0] dat16;
  logic [4:0]  len16;
  logic [7:0]  dat8;
  logic [3:0]  len8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  deserializer_flex #(.DATA_W(16), .MSB_FIRST(1'b1)) u_msb (
    .clk_i (clk), .srst_i (srst), .data_i (d[0]), .data_val_i (v[0]),
    .flush_i (f[0]), .deser_data_o (dat16), .deser_len_o (len16),
    .deser_data_val_o (val_o[0]), .deser_data_ready_i (rdy[0]),
    .overflow_o (ovf_o[0])
  );

  deserializer_flex #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i (clk), .srst_i (srst), .data_i (d[1]), .data_val_i (v[1]),
    .flush_i (f[1]), .deser_data_o (dat8), .deser_len_o (len8),
    .deser_data_val_o (val_o[1]), .deser_data_ready_i (rdy[1]),
    .overflow_o (ovf_o[1])
  );

  // Reference model: bits kept in arrival order, word built on emit.
  int          c_w   [2] = '{16, 8};
  bit          c_msbf[2] = '{1'b1, 1'b0};
  logic [63:0] mbits [2];
  int          mcnt  [2];
  bit          hval  [2];
  longint      hdata [2];
  int          hlen  [2];
  bit          movf  [2];

  function automatic longint act_data(input int k);
    return (k == 0) ? longint'(dat16) : longint'(dat8);
  endfunction

  function automatic int act_len(input int k);
    return (k == 0) ? int'(len16) : int'(len8);
  endfunction

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mbits[k] = '0; hval[k] = 0; hdata[k] = 0; hlen[k] = 0; movf[k] = 0;
    end
  endtask

  task automatic model_update(input int k);
    longint word;
    int     len;
    bit     emit;
    if (v[k]) begin
      mbits[k][mcnt[k]] = d[k];
      mcnt[k]++;
    end
    emit = (mcnt[k] == c_w[k]) || (f[k] && mcnt[k] > 0);
    word = 0;
    len  = mcnt[k];
    if (emit) begin
      for (int i = 0; i < len; i++) begin
        if (mbits[k][i])
          word = word + (longint'(1) << (c_msbf[k] ? (len - 1 - i) : i));
      end
      mcnt[k] = 0;
    end
    movf[k] = 0;
    if (emit) begin
      if (!hval[k] || rdy[k]) begin
        hval[k] = 1; hdata[k] = word; hlen[k] = len;
      end else begin
        movf[k] = 1;
      end
    end else if (hval[k] && rdy[k]) begin
      hval[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("val", k, longint'(val_o[k]), longint'(hval[k]));
      chk("ovf", k, longint'(ovf_o[k]), longint'(movf[k]));
      if (hval[k]) begin
        chk("data", k, act_data(k), hdata[k]);
        chk("len", k, longint'(act_len(k)), longint'(hlen[k]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (srst) model_reset();
    else for (int k = 0; k < 2; k++) model_update(k);
    #1;
    if (!srst) check_all();
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      d[k] = 1'b0; v[k] = 1'b0; f[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    idle_inputs();
    repeat (2) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        chk("rst_val", k, longint'(val_o[k]), 0);
        chk("rst_ovf", k, longint'(ovf_o[k]), 0);
        chk("rst_data", k, act_data(k), 0);
        chk("rst_len", k, longint'(act_len(k)), 0);
      end
    end
    srst = 1'b0;
  endtask

  // First bit sent is bits[n-1]; flush asserted with the last bit if fl.
  task automatic send_bits(input int k, input int n, input logic [15:0] bits,
                           input int gap, input bit fl);
    for (int i = n - 1; i >= 0; i--) begin
      d[k] = bits[i]; v[k] = 1'b1; f[k] = fl && (i == 0);
      cycle();
      v[k] = 1'b0; f[k] = 1'b0;
      if (i > 0) begin
        chk("no_early_val", k, longint'(val_o[k]), longint'(hval[k] && !rdy[k]));
        repeat (gap) cycle();
      end
    end
  endtask

  typedef struct {
    int          k;
    int          n;
    logic [15:0] bits;
    int          gap;
    bit          fl;
    logic [15:0] exp_data;
    int          exp_len;
  } vec_t;

  vec_t        tbl[9];
  logic [15:0] w2;

  initial begin
    tbl[0] = '{0, 16, 16'hA5C3, 0, 1'b0, 16'hA5C3, 16};
    tbl[1] = '{1,  8, 16'h00B0, 0, 1'b0, 16'h000D,  8};
    tbl[2] = '{1,  8, 16'h00B0, 2, 1'b0, 16'h000D,  8};
    tbl[3] = '{0,  5, 16'h0017, 0, 1'b1, 16'h0017,  5};
    tbl[4] = '{1,  3, 16'h0006, 1, 1'b1, 16'h0003,  3};
    tbl[5] = '{0,  1, 16'h0001, 0, 1'b1, 16'h0001,  1};
    tbl[6] = '{1,  8, 16'h0001, 0, 1'b1, 16'h0080,  8};
    tbl[7] = '{0, 16, 16'h1234, 1, 1'b0, 16'h1234, 16};
    tbl[8] = '{0, 16, 16'hFFFF, 0, 1'b1, 16'hFFFF, 16};

    rdy[0] = 1'b1; rdy[1] = 1'b1;
    model_reset();
    do_reset();

    for (int t = 0; t < 9; t++) begin
      send_bits(tbl[t].k, tbl[t].n, tbl[t].bits, tbl[t].gap, tbl[t].fl);
      chk("vec_val", t, longint'(val_o[tbl[t].k]), 1);
      chk("vec_data", t, act_data(tbl[t].k), longint'(tbl[t].exp_data));
      chk("vec_len", t, longint'(act_len(tbl[t].k)), longint'(tbl[t].exp_len));
      cycle();
      chk("vec_single", t, longint'(val_o[tbl[t].k]), 0);
    end

    // Flush with nothing collected produces no word.
    f[0] = 1'b1;
    cycle();
    f[0] = 1'b0;
    cycle();
    chk("empty_flush", 0, longint'(val_o[0]), 0);

    // Held word blocks the next one, which is dropped with one overflow pulse.
    rdy[0] = 1'b0;
    send_bits(0, 16, 16'h1234, 0, 1'b0);
    send_bits(0, 16, 16'hFFFF, 0, 1'b0);
    chk("ovf_pulse", 0, longint'(ovf_o[0]), 1);
    chk("ovf_hold", 0, act_data(0), 64'h1234);
    cycle();
    chk("ovf_once", 0, longint'(ovf_o[0]), 0);
    chk("ovf_val", 0, longint'(val_o[0]), 1);
    rdy[0] = 1'b1;
    cycle();
    chk("accept_drop", 0, longint'(val_o[0]), 0);

    // Accept in the same cycle as the next completion: no bubble, no drop.
    rdy[0] = 1'b0;
    send_bits(0, 16, 16'hAAAA, 0, 1'b0);
    w2 = 16'h5555;
    for (int i = 15; i >= 0; i--) begin
      d[0] = w2[i]; v[0] = 1'b1;
      if (i == 0) rdy[0] = 1'b1;
      cycle();
    end
    v[0] = 1'b0;
    chk("b2b_val", 0, longint'(val_o[0]), 1);
    chk("b2b_data", 0, act_data(0), 64'h5555);
    chk("b2b_ovf", 0, longint'(ovf_o[0]), 0);
    cycle();
    chk("b2b_done", 0, longint'(val_o[0]), 0);

    // Reset mid-word discards collected bits.
    send_bits(0, 7, 16'h005A, 0, 1'b0);
    do_reset();
    send_bits(0, 16, 16'hC0DE, 0, 1'b0);
    chk("post_rst_data", 0, act_data(0), 64'hC0DE);
    chk("post_rst_len", 0, longint'(act_len(0)), 16);
    cycle();

    // Random traffic on both instances against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        d[k]   = 1'($urandom_range(0, 1));
        v[k]   = ($urandom_range(0, 9) < 7);
        f[k]   = ($urandom_range(0, 9) == 0);
        rdy[k] = (n < 1500) ? ($urandom_range(0, 9) < 6) : 1'b1;
      end
      cycle();
      if (n >= 1500) begin
        chk("no_drop_rdy", 0, longint'(ovf_o[0]), 0);
        chk("no_drop_rdy", 1, longint'(ovf_o[1]), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
